mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch unit (IF) and the load/store unit (LS).
- Sits between both requesters and the memory interface.
- Arbitrates, latches the winning request, holds the memory enable until the memory responds, then returns the data or write completion to the owner.
- Includes a watchdog timeout so a silent memory cannot hang the core.

Parameters:
- LS_PRIORITY, 1: 1 means LS wins every tie; 0 means round-robin on ties.
- TIMEOUT, 255: maximum cycles in a busy state before abort. 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter. Must hold TIMEOUT.

Ports:
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse: if_rdata valid, or error
- if_rdata  out  32  fetched word, registered
- ls_req  in  1  load/store request, level, held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  access size passed to memory: 00 byte, 01 half, 10 word
- ls_addr  in  32  data address
- ls_wdata  in  32  store data, already aligned/zero-extended
- ls_done  out  1  one-cycle pulse: load data valid, store accepted, or error
- ls_rdata  out  32  raw loaded word, registered; sign extension is the LS unit's job
- err  out  1  asserted together with the done pulse when the access timed out
- mem_en  out  1  memory enable, held for the whole transaction
- mem_we  out  1  write enable
- mem_size  out  2  access size; 10 for fetches
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched store data
- mem_read_data  in  32  memory read data
- mem_read_data_valid  in  1  read data valid
- mem_write_ready  in  1  write accepted
- owner  out  2  00 none, 01 IF, 10 LS; debug/stall visibility

Behaviour:
- **Reset values:** all outputs 0; state IDLE; last_owner = IF; watchdog counter 0.
- **Reset mid-transaction:** the transaction is dropped, mem_en is 0 on the following cycle, and no done pulse is issued.
- **States:** IDLE, BUSY_IF, BUSY_LS.
- **IDLE arbitration:**
  - Eligible request: req high AND that requester's done is not high this cycle. This suppresses re-grant of a request still high in its completion cycle.
  - Only one eligible: that one wins.
  - Both eligible, LS_PRIORITY=1: LS wins.
  - Both eligible, LS_PRIORITY=0: the requester that is not last_owner wins.
  - On a grant, latch addr, we, size and wdata into registers (IF: we=0, size=10), set last_owner, and go to BUSY_x at the next edge.
- **BUSY_x:**
  - mem_en=1; mem_we, mem_addr, mem_size and mem_wdata come from the latched registers; owner reflects x.
  - The watchdog counts up each cycle from 1.
  - Completion on a read (IF, or LS with we=0): mem_read_data_valid. Capture mem_read_data into x_rdata.
  - Completion on a write: mem_write_ready. mem_read_data_valid is ignored for writes, and mem_write_ready is ignored for reads.
  - At the completion edge: x_done=1 for exactly one cycle, state goes to IDLE, and mem_en drops in that same cycle.
  - Timeout: the counter reaches TIMEOUT without completion (TIMEOUT≠0). Then x_done=1, err=1, x_rdata=0, state goes to IDLE.
  - Completion and timeout in the same cycle: completion wins, err=0.
- **Latency:**
  - Request seen in IDLE at cycle 0 → mem_en high at cycle 1.
  - Response at cycle k → done at cycle k+1.
  - Minimum read is 2 cycles when memory responds in cycle 1.
  - Back-to-back: the other pending requester is granted in the done cycle, giving mem_en at k+2. One idle memory cycle between transactions is required.
- **Requester rules:**
  - Requests and inputs are not sampled while busy; changes are ignored.
  - A requester dropping req while busy does not abort the access; the done pulse still occurs.
- **Output persistence:** x_rdata holds its value until the next completion of the same requester.
- **Width rules:** none; pure 32-bit pass-through. The counter saturates and never wraps.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, BUSY_IF, BUSY_LS)
  - owner_t constants (OWN_NONE=2'b00, OWN_IF=2'b01, OWN_LS=2'b10)
  - SIZE_WORD=2'b10
- One sub-module, mem_arb_pick: combinational two-way picker. Inputs: eligible vector, last_owner, LS_PRIORITY. Output: winner.
- The FSM, latches and watchdog stay in the top module.

Test Plan:
1. Lone fetch: if_req=1, if_addr=0x100; memory returns 0xDEADBEEF with valid at cycle 3 → mem_en cycles 1-3, mem_addr=0x100, mem_size=10; if_done pulse at cycle 4; if_rdata=0xDEADBEEF; err=0.
2. Tie, LS_PRIORITY=1: if_req and ls_req (store, addr 0x200, wdata 0x55, size 00) rise together → LS served first (mem_we=1, mem_size=00); ls_done after mem_write_ready; IF granted in the ls_done cycle; mem_en for IF one cycle later.
3. Tie, LS_PRIORITY=0, both held for 4 transactions → owner sequence LS, IF, LS, IF (last_owner=IF after reset); no requester is granted twice while the other waits.
4. Request still high in its done cycle, other requester idle → no regrant in that cycle; a fresh access starts only if req is still high one cycle later.
5. Timeout, TIMEOUT=5: LS load, memory never responds → ls_done=1, err=1, ls_rdata=0 at the 5th busy cycle; state IDLE; mem_en low.
6. Reset asserted in BUSY_IF → next cycle mem_en=0, owner=00, if_done stays 0; a new if_req is served normally after reset is released.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter; no logic, no latency.
// Owner codes double as the debug owner output and the round-robin history.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } arb_state_t;

   localparam logic [1:0] OWN_NONE  = 2'b00;
   localparam logic [1:0] OWN_IF    = 2'b01;
   localparam logic [1:0] OWN_LS    = 2'b10;

   localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker between IF and LS: zero latency.
// Never stalls; LS_PRIORITY=0 breaks ties against the previous owner.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int LS_PRIORITY = 1
) (
   input  logic [1:0] i_elig,
   input  logic [1:0] i_last_owner,
   output logic [1:0] o_winner
);

   // i_elig bit 0 is IF, bit 1 is LS
   always_comb begin
      o_winner = OWN_NONE;
      case (i_elig)
         2'b01:   o_winner = OWN_IF;
         2'b10:   o_winner = OWN_LS;
         2'b11: begin
            if (LS_PRIORITY != 0 || i_last_owner == OWN_IF) o_winner = OWN_LS;
            else                                            o_winner = OWN_IF;
         end
         default: o_winner = OWN_NONE;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and LS: grant->mem_en 1 cycle, response->done 1 cycle.
// Requesters hold req until done; a silent memory is aborted by the watchdog after TIMEOUT busy cycles.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LS_PRIORITY = 1,
   parameter int TIMEOUT     = 255,
   parameter int CNT_W       = 8
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_read_data,
   input  logic        mem_read_data_valid,
   input  logic        mem_write_ready,
   output logic [1:0]  owner
);

   localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   arb_state_t       r_state;
   logic [1:0]       r_last_owner;
   logic [CNT_W-1:0] r_cnt;
   logic             r_if_done;
   logic             r_ls_done;
   logic             r_err;
   logic [31:0]      r_if_rdata;
   logic [31:0]      r_ls_rdata;
   logic             r_mem_en;
   logic             r_mem_we;
   logic [1:0]       r_mem_size;
   logic [31:0]      r_mem_addr;
   logic [31:0]      r_mem_wdata;
   logic [1:0]       r_owner;

   logic [1:0]       w_elig;
   logic [1:0]       w_winner;
   logic             w_cmpl;
   logic             w_tmo;

   // A requester still high in its own done cycle is not re-granted.
   assign w_elig = {ls_req & ~r_ls_done, if_req & ~r_if_done};

   mem_arb_pick #(
      .LS_PRIORITY (LS_PRIORITY)
   ) u_pick (
      .i_elig       (w_elig),
      .i_last_owner (r_last_owner),
      .o_winner     (w_winner)
   );

   assign w_cmpl = r_mem_we ? mem_write_ready : mem_read_data_valid;
   assign w_tmo  = (TIMEOUT != 0) && (r_cnt == TO_V);

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_owner <= OWN_IF;
         r_cnt        <= '0;
         r_if_done    <= 1'b0;
         r_ls_done    <= 1'b0;
         r_err        <= 1'b0;
         r_if_rdata   <= '0;
         r_ls_rdata   <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_size   <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_owner      <= OWN_NONE;
      end else begin
         r_if_done <= 1'b0;
         r_ls_done <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_winner != OWN_NONE) begin
                  r_state      <= (w_winner == OWN_LS) ? BUSY_LS : BUSY_IF;
                  r_owner      <= w_winner;
                  r_last_owner <= w_winner;
                  r_mem_en     <= 1'b1;
                  r_cnt        <= CNT_W'(1);
                  if (w_winner == OWN_LS) begin
                     r_mem_addr  <= ls_addr;
                     r_mem_we    <= ls_we;
                     r_mem_size  <= ls_size;
                     r_mem_wdata <= ls_wdata;
                  end else begin
                     r_mem_addr  <= if_addr;
                     r_mem_we    <= 1'b0;
                     r_mem_size  <= SIZE_WORD;
                     r_mem_wdata <= '0;
                  end
               end
            end
            BUSY_IF, BUSY_LS: begin
               if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
               // A response arriving on the timeout cycle still counts as a success.
               if (w_cmpl || w_tmo) begin
                  r_state  <= IDLE;
                  r_mem_en <= 1'b0;
                  r_owner  <= OWN_NONE;
                  r_cnt    <= '0;
                  r_err    <= ~w_cmpl;
                  if (r_state == BUSY_IF) begin
                     r_if_done  <= 1'b1;
                     r_if_rdata <= w_cmpl ? mem_read_data : 32'h0;
                  end else begin
                     r_ls_done <= 1'b1;
                     if (!w_cmpl)       r_ls_rdata <= 32'h0;
                     else if (!r_mem_we) r_ls_rdata <= mem_read_data;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign if_done   = r_if_done;
   assign ls_done   = r_ls_done;
   assign err       = r_err;
   assign if_rdata  = r_if_rdata;
   assign ls_rdata  = r_ls_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_size  = r_mem_size;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign owner     = r_owner;

endmodule
